// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle for the bit-serial adder.
//   master: drives start/a/b/cin, observes busy/done/sum/cout.
//   slave : the adder side (opposite directions).
//   WIDTH must match the WIDTH of the attached serial_adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder built around a single 1-bit
// mux-based full-adder slice. One operand bit pair is consumed per clock,
// LSB first; the carry lives in a flop between cycles.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   bus      serial_adder_if.slave
//              start  request, sampled only in IDLE
//              a, b   operands, captured on the accepting edge
//              cin    carry-in, captured on the accepting edge
//              busy   high while adding (WIDTH cycles)
//              done   one-cycle completion pulse
//              sum    registered result of the last completed add
//              cout   registered carry-out of the last completed add
//
// {cout,sum} = a + b + cin. Latency from the accepting edge to done is WIDTH
// cycles; one add every WIDTH+2 cycles at best.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] ra_reg;
  logic [WIDTH-1:0] rb_reg;
  logic [WIDTH-1:0] ps_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             c_reg;
  logic             cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic             last_bit;
  logic             prop;
  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] ps_next;

  assign last_bit = (cnt_reg == LAST);

  // Mux-based full-adder slice. prop = b ^ c selects between the two
  // possible results: the sum bit is a inverted or passed depending on prop,
  // and the carry is a when b and c disagree, otherwise b (== c).
  assign prop    = rb_reg[0] ^ c_reg;
  assign s_bit   = ra_reg[0] ? ~prop : prop;
  assign c_next  = prop ? ra_reg[0] : rb_reg[0];
  assign ps_next = {s_bit, ps_reg[WIDTH-1:1]};

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: operand shifters, carry flop, partial sum, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_reg   <= '0;
      rb_reg   <= '0;
      ps_reg   <= '0;
      c_reg    <= 1'b0;
      cnt_reg  <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            ra_reg  <= bus.a;
            rb_reg  <= bus.b;
            c_reg   <= bus.cin;
            cnt_reg <= '0;
            ps_reg  <= '0;
          end
        end
        SHIFT: begin
          ra_reg <= ra_reg >> 1;
          rb_reg <= rb_reg >> 1;
          ps_reg <= ps_next;
          c_reg  <= c_next;
          // Hold the counter on the final bit so it can never wrap when
          // WIDTH is a power of two.
          if (last_bit) begin
            sum_reg  <= ps_next;
            cout_reg <= c_next;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode the state register directly, so they are glitch-free
  // flop outputs with no path from the inputs.
  assign bus.busy = (state_reg == SHIFT);
  assign bus.done = (state_reg == DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that sits directly downstream of the team's 1-bit mux-based full-adder cell. It feeds that cell one operand bit pair per clock and keeps the carry in a flip-flop between cycles. It assembles the WIDTH-bit sum LSB-first and reports completion with a one-cycle `done` pulse. The block trades WIDTH cycles of latency for a single adder slice.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal values are 2 and above.
- `clk`  in  1  sole clock; rising-edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  operand A; captured on the accepting edge.
- `b`  in  WIDTH  operand B; captured on the accepting edge.
- `cin`  in  1  carry-in; captured on the accepting edge.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle completion pulse; high in DONE.
- `sum`  out  WIDTH  registered result; holds the last completed sum.
- `cout`  out  1  registered carry-out of the last completed add.

## Operation
- State machine has three states: IDLE, SHIFT, DONE.
  - IDLE: on `start`=1, go to SHIFT; otherwise stay.
  - SHIFT: go to DONE when the bit counter reaches WIDTH-1; otherwise stay.
  - DONE: go to IDLE unconditionally.
- Accepting edge (IDLE with `start`=1):
  - `a`, `b` load into shift registers `ra`, `rb`.
  - `cin` loads into carry flop `c`.
  - Bit counter clears to 0.
  - Partial-sum register `ps` clears to 0.
- Each SHIFT edge:
  - Bit result: s = ra[0]^rb[0]^c.
  - Carry: c <= majority(ra[0], rb[0], c).
  - `ra` and `rb` shift right by one.
  - `ps` shifts right by one with s entering at bit WIDTH-1.
  - Counter increments.
- On the SHIFT edge with counter = WIDTH-1, the final bit is formed. On that same edge:
  - `sum` <= final `ps` value, including that last bit.
  - `cout` <= final carry.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, modulo 2^(WIDTH+1). There is no overflow flag.
- `sum` and `cout` change only on the completing edge. During SHIFT they keep the previous result.
- `start` is ignored in SHIFT and DONE; there is no queueing. Input changes after the accepting edge have no effect.
- Counter width is clog2(WIDTH). Counter wrap-around must never occur; the FSM leaves SHIFT before the counter can wrap.
- Reset (any time, including mid-SHIFT):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - `ra`, `rb`, `ps`, `c`, and counter all go to 0.
  - The in-flight add is discarded. No `done` pulse follows reset.

## Timing
- Edge 0 is the accepting edge. SHIFT edges are edges 1..WIDTH.
- `busy` is high from after edge 0 through edge WIDTH, i.e. for exactly WIDTH cycles.
- `done`, `sum`, `cout` become valid after edge WIDTH.
- `done` is high for exactly one cycle, between edges WIDTH and WIDTH+1.
- Latency from the accepting edge to `done` is WIDTH cycles.
- State returns to IDLE after edge WIDTH+1.
- Edge WIDTH+1 only clears `done` and returns to IDLE. A `start` held high during that cycle is not accepted on edge WIDTH+1.
- Back-to-back throughput: the next start is accepted on edge WIDTH+2 at the earliest, giving one add per WIDTH+2 cycles.
- `busy` and `done` are never high together.
- All outputs are registered, so there is no combinational path from input to output.

## Test plan
- Basic add, WIDTH=8: `a`=0x5A, `b`=0x3C, `cin`=0, pulse `start`.
  - Required: `busy` high 8 cycles; `done` pulses once, 8 cycles after the accepting edge.
  - Required: `sum`=0x96, `cout`=0.
- Full carry ripple: `a`=0xFF, `b`=0x01, `cin`=0 -> `sum`=0x00, `cout`=1.
- Maximum inputs: `a`=0xFF, `b`=0xFF, `cin`=1 -> `sum`=0xFF, `cout`=1.
- Ignored start and held result: after a completed add of 0x5A+0x3C (result 0x96, 0), start a new add of 0x10+0x20. Pulse `start` with new operands 0x77/0x11 mid-SHIFT.
  - Required: `sum` stays 0x96 and `cout` stays 0 until completion.
  - Required: the result is `sum`=0x30, `cout`=0, with exactly one `done` pulse.
- Reset mid-SHIFT: assert `rst` asynchronously at cycle 3 of an add of 0xAA+0x55.
  - Required: all outputs read 0 immediately, with no clock edge needed.
  - Required: no `done` pulse follows.
  - Required: a following add of 0x01+0x01 with `cin`=1 gives `sum`=0x03, `cout`=0.
- Back-to-back and randomized: hold `start`=1 continuously.
  - Required: accepts occur every 10 cycles (WIDTH+2).
  - Run 1000 random `a`, `b`, `cin` for WIDTH=8 and WIDTH=13, comparing {`cout`,`sum`} against `a`+`b`+`cin`.
